// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing helpers for the convolution engine
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int out_dim(input int in, input int k, input int stride);
        return (in - k) / stride + 1;
    endfunction

    function automatic int acc_width(input int dw, input int k, input int ch);
        return 2 * dw + $clog2(k * k * ch);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - registered multiply stage followed by a registered adder tree
module conv_window_mac #(
    parameter int N    = 27,
    parameter int DW   = 17,
    parameter int ACCW = 39,
    parameter int TAGW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  logic [N-1:0][DW-1:0]   win_i,
    input  logic [N-1:0][DW-1:0]   wgt_i,
    input  logic [TAGW-1:0]        tag_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic signed [ACCW-1:0] sum_o,
    output logic [TAGW-1:0]        tag_o
);

    localparam int PW = 2 * DW;

    logic                   s1_v_q;
    logic                   s2_v_q;
    logic [TAGW-1:0]        s1_tag_q;
    logic [TAGW-1:0]        s2_tag_q;
    logic signed [PW-1:0]   prod_q [N];
    logic signed [ACCW-1:0] sum_d;
    logic signed [ACCW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else if (en_i) begin
            s1_v_q <= valid_i;
            s2_v_q <= s1_v_q;
        end
    end

    // Operands are sign-extended before the multiply so the full product lands in PW bits.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int n = 0; n < N; n++) begin
                prod_q[n] <= PW'($signed(win_i[n])) * PW'($signed(wgt_i[n]));
            end
            s1_tag_q <= tag_i;
            sum_q    <= sum_d;
            s2_tag_q <= s1_tag_q;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int n = 0; n < N; n++) begin
            sum_d = sum_d + ACCW'(prod_q[n]);
        end
    end

    assign busy_o  = s1_v_q | s2_v_q;
    assign valid_o = s2_v_q;
    assign sum_o   = sum_q;
    assign tag_o   = s2_tag_q;

endmodule

// File: rtl/conv_tensor_engine.sv
// rtl/conv_tensor_engine.sv - sequenced 2-D convolution with bias, ReLU and stream output
module conv_tensor_engine
    import conv_pkg::*;
#(
    parameter int IN_H   = 8,
    parameter int IN_W   = 8,
    parameter int CH     = 3,
    parameter int K      = 3,
    parameter int NFILT  = 4,
    parameter int STRIDE = 1,
    parameter int DW     = 17,
    localparam int OUT_H = out_dim(IN_H, K, STRIDE),
    localparam int OUT_W = out_dim(IN_W, K, STRIDE),
    localparam int NOUT  = NFILT * OUT_H * OUT_W,
    localparam int PW    = 2 * DW,
    localparam int ACCW  = acc_width(DW, K, CH),
    localparam int RW    = ACCW + 1,
    localparam int AW    = idx_w(NOUT)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [IN_H-1:0][IN_W-1:0][CH-1:0][DW-1:0]  in_tensor,
    input  logic [NFILT-1:0][K-1:0][K-1:0][CH-1:0][DW-1:0] filt,
    input  logic [NFILT-1:0][PW-1:0]                   bias,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [RW-1:0]                              out_data,
    output logic [AW-1:0]                              out_addr,
    output logic                                       busy,
    output logic                                       done
);

    localparam int FW   = idx_w(NFILT);
    localparam int HW   = idx_w(OUT_H);
    localparam int WW   = idx_w(OUT_W);
    localparam int RIW  = idx_w(IN_H);
    localparam int CIW  = idx_w(IN_W);
    localparam int N    = K * K * CH;
    localparam int TAGW = FW + AW;

    state_t          state_q, state_d;
    logic [FW-1:0]   f_q, f_d, iss_f_q, iss_f_d;
    logic [HW-1:0]   r_q, r_d, iss_r_q, iss_r_d;
    logic [WW-1:0]   c_q, c_d, iss_c_q, iss_c_d;
    logic [AW-1:0]   a_q, a_d, iss_a_q, iss_a_d;
    logic            iss_v_q, iss_v_d;
    logic            out_valid_q;
    logic [RW-1:0]   out_data_q;
    logic [AW-1:0]   out_addr_q;
    logic            advance;
    logic            mac_busy;
    logic            s2_v;
    logic signed [ACCW-1:0] s2_sum;
    logic [TAGW-1:0] s2_tag;
    logic [FW-1:0]   s2_f;
    logic [AW-1:0]   s2_a;
    logic signed [RW-1:0] pre_relu;
    logic [N-1:0][DW-1:0] win;
    logic [N-1:0][DW-1:0] wgt;

    assign advance = !out_valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        a_d     = a_q;
        iss_v_d = advance ? 1'b0 : iss_v_q;
        iss_f_d = iss_f_q;
        iss_r_d = iss_r_q;
        iss_c_d = iss_c_q;
        iss_a_d = iss_a_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    f_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    a_d     = '0;
                end
            end
            RUN: begin
                if (advance) begin
                    iss_v_d = 1'b1;
                    iss_f_d = f_q;
                    iss_r_d = r_q;
                    iss_c_d = c_q;
                    iss_a_d = a_q;
                    a_d     = a_q + AW'(1);
                    if (c_q == WW'(OUT_W - 1)) begin
                        c_d = '0;
                        if (r_q == HW'(OUT_H - 1)) begin
                            r_d = '0;
                            if (f_q == FW'(NFILT - 1)) begin
                                state_d = DRAIN;
                            end else begin
                                f_d = f_q + FW'(1);
                            end
                        end else begin
                            r_d = r_q + HW'(1);
                        end
                    end else begin
                        c_d = c_q + WW'(1);
                    end
                end
            end
            DRAIN: begin
                // Upstream stages empty means the output register holds the final result.
                if (!iss_v_q && !mac_busy && out_valid_q && out_ready) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            a_q     <= '0;
            iss_v_q <= 1'b0;
            iss_f_q <= '0;
            iss_r_q <= '0;
            iss_c_q <= '0;
            iss_a_q <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            a_q     <= a_d;
            iss_v_q <= iss_v_d;
            iss_f_q <= iss_f_d;
            iss_r_q <= iss_r_d;
            iss_c_q <= iss_c_d;
            iss_a_q <= iss_a_d;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            logic [RIW-1:0] row;
            logic [CIW-1:0] col;
            assign row = RIW'(int'(iss_r_q) * STRIDE + i);
            assign col = CIW'(int'(iss_c_q) * STRIDE + j);
            for (genvar k = 0; k < CH; k++) begin : g_ch
                assign win[(i * K + j) * CH + k] = in_tensor[row][col][k];
                assign wgt[(i * K + j) * CH + k] = filt[iss_f_q][i][j][k];
            end
        end
    end

    conv_window_mac #(
        .N    (N),
        .DW   (DW),
        .ACCW (ACCW),
        .TAGW (TAGW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance),
        .valid_i (iss_v_q),
        .win_i   (win),
        .wgt_i   (wgt),
        .tag_i   ({iss_f_q, iss_a_q}),
        .busy_o  (mac_busy),
        .valid_o (s2_v),
        .sum_o   (s2_sum),
        .tag_o   (s2_tag)
    );

    assign {s2_f, s2_a} = s2_tag;
    assign pre_relu     = RW'(s2_sum) + RW'($signed(bias[s2_f]));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else if (advance) begin
            out_valid_q <= s2_v;
            out_data_q  <= pre_relu[RW-1] ? '0 : pre_relu;
            out_addr_q  <= s2_a;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_tensor_engine.sv
// tb/tb_conv_tensor_engine.sv - randomized self-checking bench against a loop-based convolution model
module tb_conv_tensor_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, out_ready, out_valid, busy, done;
    logic [39:0] out_data;
    logic [7:0]  out_addr;
    logic s_rst, s_start, s_out_ready, s_out_valid, s_busy, s_done;
    logic [39:0] s_out_data;
    logic [5:0]  s_out_addr;

    logic [7:0][7:0][2:0][16:0]       tens;
    logic [6:0][6:0][2:0][16:0]       s_tens;
    logic [3:0][2:0][2:0][2:0][16:0]  filt;
    logic [3:0][33:0]                 bias;

    conv_tensor_engine dut (
        .clk(clk), .rst(rst), .start(start), .in_tensor(tens), .filt(filt), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    conv_tensor_engine #(.IN_H(7), .IN_W(7), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst(s_rst), .start(s_start), .in_tensor(s_tens), .filt(filt), .bias(bias),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_addr(s_out_addr), .busy(s_busy), .done(s_done)
    );

    int     n_cmp = 0;
    int     n_mis = 0;
    longint exp_q [$];
    bit     sel = 1'b0;
    logic   m_valid, m_busy, m_done;
    longint m_data;
    longint m_addr;

    always_comb begin
        m_valid = sel ? s_out_valid : out_valid;
        m_busy  = sel ? s_busy : busy;
        m_done  = sel ? s_done : done;
        m_data  = sel ? longint'(s_out_data) : longint'(out_data);
        m_addr  = sel ? longint'(s_out_addr) : longint'(out_addr);
    end

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic set_ready(input bit b);
        if (sel) s_out_ready = b; else out_ready = b;
    endtask

    task automatic set_start(input bit b);
        if (sel) s_start = b; else start = b;
    endtask

    // Reference: direct triple sum over the window for every (filter,row,col) in address order.
    task automatic build_model();
        int ih = sel ? 7 : 8;
        int st = sel ? 2 : 1;
        int od = (ih - 3) / st + 1;
        exp_q.delete();
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < od; r++)
                for (int c = 0; c < od; c++) begin
                    longint acc = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            for (int k = 0; k < 3; k++) begin
                                longint tv, fv;
                                tv = sel ? longint'($signed(s_tens[r*st+i][c*st+j][k]))
                                         : longint'($signed(tens[r*st+i][c*st+j][k]));
                                fv = longint'($signed(filt[f][i][j][k]));
                                acc += tv * fv;
                            end
                    acc += longint'($signed(bias[f]));
                    exp_q.push_back(acc < 0 ? 0 : acc);
                end
    endtask

    task automatic run(input bit rnd, input int rst_at, input int pulse_at, input bit timing);
        int nout = exp_q.size();
        int n = 0;
        int cyc = 0;
        int first = -1;
        bit v, rdy;
        longint d, a;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("busy_after_start", m_busy, 1);
        while (n < nout && cyc < 3000) begin
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            set_ready(rdy);
            if (cyc == pulse_at) set_start(1'b1);
            v = m_valid; d = m_data; a = m_addr;
            @(posedge clk); cyc++; #1;
            set_start(1'b0);
            if (v && rdy) begin
                check("data", d, exp_q[n]);
                check("addr", a, n);
                n++;
                if (n == rst_at) begin
                    if (sel) s_rst = 1'b1; else rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0; s_rst = 1'b0;
                    check("rst_valid", m_valid, 0);
                    check("rst_busy", m_busy, 0);
                    set_ready(1'b1);
                    return;
                end
            end else if (v) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, d);
                check("hold_addr", m_addr, a);
            end
            if (first < 0 && m_valid) first = cyc;
        end
        set_ready(1'b1);
        if (n < nout) begin
            check("outputs_seen", n, nout);
            return;
        end
        check("done_high", m_done, 1);
        check("busy_at_done", m_busy, 0);
        if (timing) begin
            check("first_valid_edge", first, 4);
            check("last_handshake_edge", cyc, nout + 4);
        end
        @(posedge clk); #1;
        check("done_pulse_end", m_done, 0);
        check("idle_valid", m_valid, 0);
    endtask

    task automatic randomize_inputs();
        for (int h = 0; h < 8; h++)
            for (int w = 0; w < 8; w++)
                for (int k = 0; k < 3; k++) tens[h][w][k] = 17'($urandom());
        for (int f = 0; f < 4; f++) begin
            bias[f] = 34'({$urandom(), $urandom()});
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    for (int k = 0; k < 3; k++) filt[f][i][j][k] = 17'($urandom());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_rst = 1'b1; start = 1'b0; s_start = 1'b0;
        out_ready = 1'b1; s_out_ready = 1'b1;
        tens = '0; s_tens = '0; filt = '0; bias = '0;
        @(posedge clk); #1;
        rst = 1'b0; s_rst = 1'b0;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data", longint'(out_data), 0);
        check("reset_addr", longint'(out_addr), 0);

        for (int h = 0; h < 8; h++)
            for (int w = 0; w < 8; w++)
                for (int k = 0; k < 3; k++) tens[h][w][k] = 17'd1;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    for (int k = 0; k < 3; k++) filt[f][i][j][k] = 17'd1;
        build_model();
        run(1'b0, -1, -1, 1'b1);

        bias[2] = -34'sd30;
        build_model();
        run(1'b0, -1, -1, 1'b1);

        tens = '0; filt = '0; bias = '0;
        tens[3][4][1] = -17'sd5;
        filt[0][1][2][1] = 17'sd7;
        build_model();
        run(1'b0, -1, -1, 1'b0);
        filt[0][1][2][1] = -17'sd7;
        build_model();
        check("model_addr14", exp_q[14], 35);
        run(1'b0, -1, -1, 1'b0);

        randomize_inputs();
        build_model();
        run(1'b0, -1, -1, 1'b1);
        run(1'b1, -1, 40, 1'b0);
        run(1'b0, 50, -1, 1'b0);
        run(1'b0, -1, 20, 1'b1);

        sel = 1'b1;
        for (int h = 0; h < 7; h++)
            for (int w = 0; w < 7; w++)
                for (int k = 0; k < 3; k++) s_tens[h][w][k] = 17'(h * 64 + w * 4 + k);
        build_model();
        run(1'b0, -1, -1, 1'b1);
        run(1'b1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
